// File: rtl/lr_shift_iter_pkg.sv
// lr_shift_pkg: shared definitions for the iterative left/right shifter.
//   MODE_*       3-bit operation encodings on MODE
//   state_e      controller states IDLE / SHIFT / DONE
//   is_right()   mode moves bits toward the LSB
//   is_rotate()  mode wraps bits around instead of filling
//   is_pass()    mode leaves the operand untouched (PASS and reserved codes)
//   fill_bit()   bit shifted in for non-rotating modes
package lr_shift_pkg;

  localparam logic [2:0] MODE_PASS = 3'd0;
  localparam logic [2:0] MODE_SLL  = 3'd1;
  localparam logic [2:0] MODE_SRL  = 3'd2;
  localparam logic [2:0] MODE_SRA  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic is_right(input logic [2:0] mode);
    return (mode == MODE_SRL) || (mode == MODE_SRA) || (mode == MODE_ROR);
  endfunction

  function automatic logic is_rotate(input logic [2:0] mode);
    return (mode == MODE_ROL) || (mode == MODE_ROR);
  endfunction

  // Reserved encodings 6 and 7 behave as PASS.
  function automatic logic is_pass(input logic [2:0] mode);
    return (mode == MODE_PASS) || (mode > MODE_ROR);
  endfunction

  function automatic logic fill_bit(input logic [2:0] mode, input logic msb);
    return (mode == MODE_SRA) ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/lr_shift_iter_if.sv
// lr_shift_iter_if: request/result handshake bundle for lr_shift_iter.
//   Request : IN_VALID, IN_READY, DATA_IN[WIDTH], SHAMT[SHW], MODE[3], FLUSH
//   Result  : OUT_VALID, OUT_READY, DATA_OUT[WIDTH], BUSY
//   master  : the requester/consumer side; slave: the shifter.
interface lr_shift_iter_if #(
  parameter int unsigned WIDTH = 32
) ();
  localparam int unsigned SHW = $clog2(WIDTH);

  logic             FLUSH;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] DATA_IN;
  logic [SHW-1:0]   SHAMT;
  logic [2:0]       MODE;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] DATA_OUT;
  logic             BUSY;

  modport master (
    output FLUSH, IN_VALID, DATA_IN, SHAMT, MODE, OUT_READY,
    input  IN_READY, OUT_VALID, DATA_OUT, BUSY
  );

  modport slave (
    input  FLUSH, IN_VALID, DATA_IN, SHAMT, MODE, OUT_READY,
    output IN_READY, OUT_VALID, DATA_OUT, BUSY
  );
endinterface

// File: rtl/lr_shift_iter_step.sv
// lr_shift_step: combinational single-cycle shift/rotate stage.
//   data_i   operand
//   k_i      positions to move this cycle, 0..STEP
//   right_i  1 = toward LSB, 0 = toward MSB
//   rotate_i 1 = wrap bits around, 0 = insert fill_i
//   fill_i   bit inserted for non-rotating shifts
//   data_o   shifted result
module lr_shift_step #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned STEP  = 4,
  localparam int unsigned KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [KW-1:0]    k_i,
  input  logic             right_i,
  input  logic             rotate_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  // The operand is placed next to a WIDTH-bit companion word (a copy of
  // itself for rotates, the fill pattern otherwise); shifting the double
  // word and keeping the operand half yields every mode with one shifter.
  logic [2*WIDTH-1:0] ext;
  logic [2*WIDTH-1:0] moved;

  always_comb begin
    ext    = '0;
    moved  = '0;
    data_o = '0;
    if (right_i) begin
      ext    = {(rotate_i ? data_i : {WIDTH{fill_i}}), data_i};
      moved  = ext >> k_i;
      data_o = moved[WIDTH-1:0];
    end else begin
      ext    = {data_i, (rotate_i ? data_i : {WIDTH{1'b0}})};
      moved  = ext << k_i;
      data_o = moved[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/lr_shift_iter.sv
// lr_shift_iter: multi-cycle shifter moving up to STEP positions per clock.
//   CLK    clock, rising edge
//   RST_N  asynchronous active-low reset
//   bus    lr_shift_iter_if.slave: request (IN_VALID/IN_READY, DATA_IN,
//          SHAMT, MODE), result (OUT_VALID/OUT_READY, DATA_OUT), FLUSH, BUSY
// A request is captured in IDLE, shifted in SHIFT for ceil(SHAMT/STEP)
// cycles, and held in DONE until the consumer accepts it.
module lr_shift_iter
  import lr_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic           CLK,
  input  logic           RST_N,
  lr_shift_iter_if.slave bus
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned KW  = $clog2(STEP + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [WIDTH-1:0] dout_q,  dout_d;
  logic [SHW-1:0]   rem_q,   rem_d;
  logic [2:0]       mode_q,  mode_d;
  logic             fill_q,  fill_d;

  logic [KW-1:0]    k;
  logic [SHW-1:0]   rem_left;
  logic [WIDTH-1:0] step_out;

  // k = min(remaining, STEP); remaining never reaches WIDTH, so the
  // truncating cast of k back to SHW bits is lossless.
  always_comb begin
    if (32'(rem_q) >= STEP) k = KW'(STEP);
    else                    k = KW'(rem_q);
    rem_left = rem_q - SHW'(k);
  end

  lr_shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data_i   (data_q),
    .k_i      (k),
    .right_i  (is_right(mode_q)),
    .rotate_i (is_rotate(mode_q)),
    .fill_i   (fill_q),
    .data_o   (step_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    if (bus.FLUSH) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.IN_VALID) begin
            data_d = bus.DATA_IN;
            mode_d = bus.MODE;
            // SRA fill is frozen at acceptance so every step replicates it.
            fill_d = fill_bit(bus.MODE, bus.DATA_IN[WIDTH-1]);
            if ((bus.SHAMT == '0) || is_pass(bus.MODE)) begin
              state_d = DONE;
              dout_d  = bus.DATA_IN;
              rem_d   = '0;
            end else begin
              state_d = SHIFT;
              rem_d   = bus.SHAMT;
            end
          end
        end
        SHIFT: begin
          data_d = step_out;
          rem_d  = rem_left;
          if (rem_left == '0) begin
            state_d = DONE;
            dout_d  = step_out;
          end
        end
        DONE: begin
          if (bus.OUT_READY) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      data_q  <= '0;
      dout_q  <= '0;
      rem_q   <= '0;
      mode_q  <= MODE_PASS;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
    end
  end

  assign bus.IN_READY  = (state_q == IDLE);
  assign bus.OUT_VALID = (state_q == DONE);
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.DATA_OUT  = dout_q;

endmodule

// File: tb/tb_lr_shift_iter.sv
module tb_lr_shift_iter;
  localparam int unsigned W    = 32;
  localparam int unsigned STEP = 4;
  localparam int unsigned SHW  = 5;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  lr_shift_iter_if #(.WIDTH(W)) bus_if ();

  lr_shift_iter #(
    .WIDTH (W),
    .STEP  (STEP)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] last_res = '0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: the whole shift done at once with native operators.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [SHW-1:0] sh,
                                         input logic [2:0] mode);
    int unsigned s;
    s = 32'(sh);
    case (mode)
      3'd1:    return d << s;
      3'd2:    return d >> s;
      3'd3:    return W'($signed(d) >>> s);
      3'd4:    return (d << s) | (d >> (W - s));
      3'd5:    return (d >> s) | (d << (W - s));
      default: return d;
    endcase
  endfunction

  function automatic int exp_lat(input logic [SHW-1:0] sh, input logic [2:0] mode);
    if (mode >= 3'd1 && mode <= 3'd5 && sh != '0)
      return (int'(sh) + int'(STEP) - 1) / int'(STEP);
    return 0;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full transaction; hold = cycles OUT_READY stays low once the result
  // is up (0 = OUT_READY high throughout).
  task automatic run_op(input logic [W-1:0] d, input logic [SHW-1:0] sh,
                        input logic [2:0] mode, input int hold);
    logic [W-1:0] exp;
    int lat;
    int n;
    exp = model(d, sh, mode);
    lat = exp_lat(sh, mode);
    check("in_ready_idle", W'(bus_if.IN_READY), 1);
    bus_if.OUT_READY = (hold == 0);
    bus_if.IN_VALID  = 1'b1;
    bus_if.DATA_IN   = d;
    bus_if.SHAMT     = sh;
    bus_if.MODE      = mode;
    tick();
    bus_if.IN_VALID = 1'b0;
    bus_if.DATA_IN  = $urandom;
    n = 0;
    while (!bus_if.OUT_VALID && n < 200) begin
      check("busy_shift", W'(bus_if.BUSY), 1);
      check("in_ready_shift", W'(bus_if.IN_READY), 0);
      tick();
      n++;
    end
    check("latency", W'(n), W'(lat));
    check("result", bus_if.DATA_OUT, exp);
    check("busy_done", W'(bus_if.BUSY), 1);
    for (int h = 0; h < hold; h++) begin
      bus_if.IN_VALID = 1'b1;
      bus_if.DATA_IN  = $urandom;
      bus_if.SHAMT    = SHW'($urandom);
      bus_if.MODE     = 3'($urandom);
      tick();
      check("hold_valid", W'(bus_if.OUT_VALID), 1);
      check("hold_data", bus_if.DATA_OUT, exp);
      check("hold_in_ready", W'(bus_if.IN_READY), 0);
    end
    bus_if.OUT_READY = 1'b1;
    tick();
    bus_if.IN_VALID  = 1'b0;
    bus_if.OUT_READY = 1'b0;
    check("post_valid", W'(bus_if.OUT_VALID), 0);
    check("post_in_ready", W'(bus_if.IN_READY), 1);
    check("post_data", bus_if.DATA_OUT, exp);
    last_res = exp;
    if (hold > 0) begin
      tick();
      check("not_queued", W'(bus_if.BUSY), 0);
    end
  endtask

  initial begin
    bus_if.FLUSH     = 1'b0;
    bus_if.IN_VALID  = 1'b0;
    bus_if.DATA_IN   = '0;
    bus_if.SHAMT     = '0;
    bus_if.MODE      = '0;
    bus_if.OUT_READY = 1'b0;

    tick();
    tick();
    check("rst_valid", W'(bus_if.OUT_VALID), 0);
    check("rst_busy", W'(bus_if.BUSY), 0);
    check("rst_data", bus_if.DATA_OUT, 0);
    RST_N = 1'b1;
    tick();
    check("rst_in_ready", W'(bus_if.IN_READY), 1);

    // Directed cases
    run_op(32'h0000_0001, 5'd5,  3'd1, 0);
    run_op(32'h8000_0000, 5'd31, 3'd3, 0);
    run_op(32'h8000_0000, 5'd31, 3'd2, 1);
    run_op(32'h0000_00F1, 5'd4,  3'd5, 0);
    run_op(32'h8000_0001, 5'd1,  3'd4, 2);
    run_op(32'h1234_5678, 5'd9,  3'd0, 0);
    run_op(32'hCAFE_F00D, 5'd9,  3'd7, 0);
    run_op(32'h7654_3210, 5'd31, 3'd4, 0);
    run_op(32'hDEAD_BEEF, 5'd0,  3'd1, 5);

    // FLUSH in the second SHIFT cycle
    bus_if.IN_VALID = 1'b1;
    bus_if.DATA_IN  = 32'h1234_5678;
    bus_if.SHAMT    = 5'd20;
    bus_if.MODE     = 3'd1;
    tick();
    bus_if.IN_VALID = 1'b0;
    tick();
    bus_if.FLUSH = 1'b1;
    tick();
    bus_if.FLUSH = 1'b0;
    check("flush_in_ready", W'(bus_if.IN_READY), 1);
    check("flush_busy", W'(bus_if.BUSY), 0);
    check("flush_data", bus_if.DATA_OUT, last_res);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("flush_no_valid", W'(bus_if.OUT_VALID), 0);
    end
    // FLUSH beats IN_VALID in IDLE
    bus_if.FLUSH    = 1'b1;
    bus_if.IN_VALID = 1'b1;
    tick();
    bus_if.FLUSH    = 1'b0;
    bus_if.IN_VALID = 1'b0;
    check("flush_prio", W'(bus_if.BUSY), 0);
    run_op(32'h1234_5678, 5'd20, 3'd1, 1);

    // Asynchronous reset mid-SHIFT
    bus_if.IN_VALID = 1'b1;
    bus_if.DATA_IN  = 32'hFFFF_FFFF;
    bus_if.SHAMT    = 5'd30;
    bus_if.MODE     = 3'd2;
    tick();
    bus_if.IN_VALID = 1'b0;
    tick();
    #2 RST_N = 1'b0;
    #1;
    check("arst_valid", W'(bus_if.OUT_VALID), 0);
    check("arst_busy", W'(bus_if.BUSY), 0);
    check("arst_data", bus_if.DATA_OUT, 0);
    tick();
    RST_N = 1'b1;
    tick();
    check("arst_in_ready", W'(bus_if.IN_READY), 1);
    last_res = '0;
    run_op(32'h0F0F_0F0F, 5'd13, 3'd5, 0);

    // Randomized
    for (int i = 0; i < 60; i++) begin
      run_op(W'($urandom), SHW'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
